system_0_cpu_0_oci_dct_sequencer: RTL and testbench

SYSTEM_0_CPU_0_OCI_DCT_SEQUENCER -- requirements
Module: system_0_cpu_0_oci_dct_sequencer

---
 rtl/system_0_cpu_0_oci_dct_sequencer.sv | 155 +++++++++++++++
 tb/tb_system_0_cpu_0_oci_dct_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_0_cpu_0_oci_dct_sequencer.sv
// -----------------------------------------------------------------------------
// system_0_cpu_0_oci_dct_sequencer
//
// Packs 2-bit trace atoms into a 30-bit buffer (15 atoms max) and hands the
// packed word {count, buffer} downstream. A word is emitted when the buffer
// fills, when a partially filled buffer has been idle long enough, or when the
// test is ending. Once the test has ended and all trace is drained, the block
// parks in DONE until reset.
//
// Ports:
//   clk            rising-edge clock for all state
//   reset          asynchronous active-high reset
//   trace_en       atom capture enable
//   atom_valid     atom present this cycle (source cannot stall)
//   atom_data[1:0] atom payload
//   test_ending    end-of-test request, sampled every cycle
//   out_valid      packed word available (high exactly while in EMIT)
//   out_data[33:0] packed word {dct_count, dct_buffer}
//   out_ready      downstream accepts out_data
//   dct_buffer     live packing buffer; bits above 2*dct_count read 0
//   dct_count      atoms currently held (0..15)
//   test_has_ended all trace drained after test_ending
//   overflow       sticky: at least one atom was dropped
//   drop_count     saturating count of dropped atoms
//   dbg_state      current FSM state (FILL=0, EMIT=1, DONE=2)
//
// Handshake: a word transfers on every rising edge where out_valid && out_ready
// are both high. Once out_valid rises, out_data is held stable and out_valid
// stays high until that transfer; out_valid never depends on out_ready.
// The atom source has no ready: atoms that arrive while the block cannot take
// them (EMIT or DONE) are dropped and counted.
// -----------------------------------------------------------------------------
module system_0_cpu_0_oci_dct_sequencer #(
  parameter int FLUSH_TIMEOUT = 64,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trace_en,
  input  logic                  atom_valid,
  input  logic [1:0]            atom_data,
  input  logic                  test_ending,
  output logic                  out_valid,
  output logic [33:0]           out_data,
  input  logic                  out_ready,
  output logic [29:0]           dct_buffer,
  output logic [3:0]            dct_count,
  output logic                  test_has_ended,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [29:0] buf_nxt;
  logic [3:0]  cnt_nxt;
  logic [7:0]  idle_cnt;
  logic [7:0]  idle_nxt;
  logic        end_pending;
  logic        end_now;
  logic        take;
  logic        accept;
  logic        drop;
  logic        timeout_hit;

  assign take   = atom_valid && trace_en;
  assign accept = take && (state == FILL);
  assign drop   = take && (state != FILL);

  // A same-cycle test_ending acts immediately, so out_valid (or DONE) follows
  // one cycle after the request rather than two.
  assign end_now = end_pending || (test_ending && (state != DONE));

  // The idle counter "reaches" FLUSH_TIMEOUT-1 in the cycle whose increment
  // would produce that value; the flush is decided in that same cycle.
  assign timeout_hit = (state == FILL) && !accept && (dct_count != 4'd0) &&
                       ((int'(idle_cnt) + 1) >= (FLUSH_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    buf_nxt   = dct_buffer;
    cnt_nxt   = dct_count;
    idle_nxt  = idle_cnt;
    case (state)
      FILL: begin
        if (accept) begin
          buf_nxt  = dct_buffer | ({28'd0, atom_data} << {dct_count, 1'b0});
          cnt_nxt  = dct_count + 4'd1;
          idle_nxt = 8'd0;
        end else if (dct_count == 4'd0) begin
          idle_nxt = 8'd0;
        end else begin
          idle_nxt = idle_cnt + 8'd1;
        end
        // Full, timeout and end-of-test all funnel into one EMIT decision.
        if ((cnt_nxt == 4'd15) || timeout_hit || (end_now && (cnt_nxt != 4'd0))) begin
          state_nxt = EMIT;
        end else if (end_now) begin
          state_nxt = DONE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          buf_nxt   = 30'd0;
          cnt_nxt   = 4'd0;
          idle_nxt  = 8'd0;
          state_nxt = end_now ? DONE : FILL;
        end
      end
      DONE: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      dct_buffer  <= 30'd0;
      dct_count   <= 4'd0;
      idle_cnt    <= 8'd0;
      end_pending <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      state       <= state_nxt;
      dct_buffer  <= buf_nxt;
      dct_count   <= cnt_nxt;
      idle_cnt    <= idle_nxt;
      end_pending <= end_now;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

  assign out_valid      = (state == EMIT);
  assign test_has_ended = (state == DONE);
  assign out_data       = {dct_count, dct_buffer};
  assign dbg_state      = state;

endmodule

// File: tb/tb_system_0_cpu_0_oci_dct_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for system_0_cpu_0_oci_dct_sequencer. Two instances share all inputs:
// dut_a uses an 8-bit drop counter, dut_b a 2-bit one (saturation at 3).
// A queue-based model of the packing behaviour runs on the clock; a compare
// process checks both instances against it on every falling edge. Directed
// scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_system_0_cpu_0_oci_dct_sequencer;

  localparam int FT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       trace_en    = 1'b0;
  logic       atom_valid  = 1'b0;
  logic [1:0] atom_data   = 2'd0;
  logic       test_ending = 1'b0;
  logic       out_ready   = 1'b0;

  logic        a_out_valid, b_out_valid;
  logic [33:0] a_out_data, b_out_data;
  logic [29:0] a_dct_buffer, b_dct_buffer;
  logic [3:0]  a_dct_count, b_dct_count;
  logic        a_test_has_ended, b_test_has_ended;
  logic        a_overflow, b_overflow;
  logic [7:0]  a_drop_count;
  logic [1:0]  b_drop_count;
  logic [1:0]  a_dbg_state, b_dbg_state;

  system_0_cpu_0_oci_dct_sequencer #(.FLUSH_TIMEOUT(FT), .DROP_CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .trace_en(trace_en), .atom_valid(atom_valid),
    .atom_data(atom_data), .test_ending(test_ending), .out_valid(a_out_valid),
    .out_data(a_out_data), .out_ready(out_ready), .dct_buffer(a_dct_buffer),
    .dct_count(a_dct_count), .test_has_ended(a_test_has_ended),
    .overflow(a_overflow), .drop_count(a_drop_count), .dbg_state(a_dbg_state)
  );

  system_0_cpu_0_oci_dct_sequencer #(.FLUSH_TIMEOUT(FT), .DROP_CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .trace_en(trace_en), .atom_valid(atom_valid),
    .atom_data(atom_data), .test_ending(test_ending), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_ready(out_ready), .dct_buffer(b_dct_buffer),
    .dct_count(b_dct_count), .test_has_ended(b_test_has_ended),
    .overflow(b_overflow), .drop_count(b_drop_count), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Atoms held so far, whether a word is waiting downstream, whether the
  // test has fully ended, and plain integer counts for idle time and drops.
  logic [1:0] m_atoms[$];
  bit         m_word;
  bit         m_done;
  bit         m_end;
  int         m_idle;
  int         m_drops;

  task automatic model_reset();
    m_atoms.delete();
    m_word  = 0;
    m_done  = 0;
    m_end   = 0;
    m_idle  = 0;
    m_drops = 0;
  endtask

  task automatic model_step();
    bit take;
    bit timed_out;
    take      = atom_valid && trace_en;
    timed_out = 0;
    if (m_done) begin
      if (take) m_drops++;
    end else if (m_word) begin
      if (take) m_drops++;
      if (test_ending) m_end = 1;
      if (out_ready) begin
        m_word = 0;
        m_atoms.delete();
        m_idle = 0;
        if (m_end) m_done = 1;
      end
    end else begin
      if (test_ending) m_end = 1;
      if (take) begin
        m_atoms.push_back(atom_data);
        m_idle = 0;
      end else if (m_atoms.size() > 0) begin
        m_idle++;
        timed_out = (m_idle >= FT - 1);
      end
      if (m_atoms.size() == 15 || timed_out || (m_end && m_atoms.size() > 0)) m_word = 1;
      else if (m_end) m_done = 1;
    end
  endtask

  function automatic logic [29:0] model_buffer();
    logic [29:0] b;
    b = '0;
    foreach (m_atoms[i]) b[2*i +: 2] = m_atoms[i];
    return b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- compare process ----------------
  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [3:0]  e_cnt;
      logic [29:0] e_buf;
      e_cnt = 4'(m_atoms.size());
      e_buf = model_buffer();
      check("a_out_valid", a_out_valid, m_word);
      check("b_out_valid", b_out_valid, m_word);
      check("a_ended", a_test_has_ended, m_done);
      check("b_ended", b_test_has_ended, m_done);
      check("a_count", a_dct_count, e_cnt);
      check("b_count", b_dct_count, e_cnt);
      check("a_buffer", a_dct_buffer, e_buf);
      check("b_buffer", b_dct_buffer, e_buf);
      check("a_overflow", a_overflow, m_drops > 0);
      check("b_overflow", b_overflow, m_drops > 0);
      check("a_drops", a_drop_count, (m_drops > 255) ? 255 : m_drops);
      check("b_drops", b_drop_count, (m_drops > 3) ? 3 : m_drops);
      if (m_word) begin
        check("a_out_data", a_out_data, {e_cnt, e_buf});
        check("b_out_data", b_out_data, {e_cnt, e_buf});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge and are consumed at the next.
  task automatic step(input bit v, input logic [1:0] d, input bit tend, input bit rdy,
                      input bit te = 1'b1);
    atom_valid  = v;
    atom_data   = d;
    test_ending = tend;
    out_ready   = rdy;
    trace_en    = te;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    atom_valid  = 1'b0;
    test_ending = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    #1 reset = 1'b1;
    #1 cmp_en = 1;
    @(posedge clk);
    #1;
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_count", a_dct_count, 4'd0);
    check("rst_ended", a_test_has_ended, 1'b0);
    check("rst_overflow", a_overflow, 1'b0);
    check("rst_drops", a_drop_count, 8'd0);
    reset = 1'b0;

    // Full word: 15 atoms of 2'b01.
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 1);
    check("full_valid", a_out_valid, 1'b1);
    check("full_word", a_out_data, 34'h3D5555555);
    step(0, 2'd0, 0, 1);
    check("full_drained_count", a_dct_count, 4'd0);
    check("full_drained_valid", a_out_valid, 1'b0);

    // Timeout: atoms 3,2,1 then idle.
    step(1, 2'd3, 0, 0);
    step(1, 2'd2, 0, 0);
    step(1, 2'd1, 0, 0);
    check("to_buffer", a_dct_buffer, 30'h1B);
    step(0, 2'd0, 0, 0);
    step(0, 2'd0, 0, 0);
    check("to_not_yet", a_out_valid, 1'b0);
    step(0, 2'd0, 0, 0);
    check("to_valid", a_out_valid, 1'b1);
    check("to_word", a_out_data, 34'h0C000001B);

    // Backpressure: 5 atoms dropped while the word waits.
    for (int i = 0; i < 5; i++) step(1, 2'(i), 0, 0);
    check("bp_word_stable", a_out_data, 34'h0C000001B);
    check("bp_overflow", a_overflow, 1'b1);
    check("bp_drops", a_drop_count, 8'd5);
    check("bp_drops_sat", b_drop_count, 2'd3);
    step(1, 2'd2, 0, 0, 0);
    check("bp_disabled_no_drop", a_drop_count, 8'd5);
    step(0, 2'd0, 0, 1);
    check("bp_consumed", a_out_valid, 1'b0);
    step(1, 2'd3, 0, 0, 0);
    check("fill_disabled_ignored", a_dct_count, 4'd0);

    // End of test with an atom in the same cycle as test_ending.
    step(1, 2'd0, 0, 0);
    step(1, 2'd3, 0, 0);
    step(1, 2'd2, 1, 0);
    check("eot_valid", a_out_valid, 1'b1);
    check("eot_word", a_out_data, 34'h0C000002C);
    step(0, 2'd0, 0, 1);
    check("eot_ended", a_test_has_ended, 1'b1);
    check("eot_no_valid", a_out_valid, 1'b0);
    step(1, 2'd1, 0, 1);
    check("done_drop", a_drop_count, 8'd6);
    check("done_drop_sat", b_drop_count, 2'd3);
    check("done_holds", a_test_has_ended, 1'b1);

    // Reset mid-EMIT with 7 atoms held.
    pulse_reset();
    for (int i = 0; i < 7; i++) step(1, 2'(i % 4), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 0);
    check("r7_valid", a_out_valid, 1'b1);
    check("r7_count", a_dct_count, 4'd7);
    check("r7_buffer", a_dct_buffer, 30'h24E4);
    #2 reset = 1'b1;
    #1;
    check("async_valid", a_out_valid, 1'b0);
    check("async_count", a_dct_count, 4'd0);
    check("async_buffer", a_dct_buffer, 30'd0);
    check("async_data", a_out_data, 34'd0);
    check("async_ended", a_test_has_ended, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 2'd2, 0, 0);
    check("after_rst_buffer", a_dct_buffer, 30'h2);
    check("after_rst_count", a_dct_count, 4'd1);

    // Full and test_ending together: exactly one word, then DONE.
    pulse_reset();
    for (int i = 0; i < 14; i++) step(1, 2'b01, 0, 0);
    step(1, 2'b01, 1, 0);
    check("fe_valid", a_out_valid, 1'b1);
    check("fe_word", a_out_data, 34'h3D5555555);
    step(0, 2'd0, 0, 0);
    check("fe_hold", a_out_valid, 1'b1);
    step(0, 2'd0, 0, 1);
    check("fe_ended", a_test_has_ended, 1'b1);
    step(0, 2'd0, 0, 1);
    check("fe_single_word", a_out_valid, 1'b0);

    // Mixed traffic, checked by the model only.
    pulse_reset();
    for (int i = 0; i < 60; i++) begin
      step(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0,
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0));
      if (i % 20 == 19) repeat (4) step(0, 2'd0, 0, 1);
    end

    // test_ending with an empty buffer.
    pulse_reset();
    step(0, 2'd0, 1, 1);
    check("empty_end_ended", a_test_has_ended, 1'b1);
    check("empty_end_no_valid", a_out_valid, 1'b0);
    repeat (3) step(0, 2'd0, 0, 1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
